// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier: one WIDTH-bit add per cycle, 2*WIDTH-bit product.
// Optional SHIFT_ADD_MULT_ZERO_SKIP_EN: a zero operand finishes straight from IDLE.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               inp_clk,
    input  logic               inp_rst,
    input  logic               inp_start,
    input  logic [WIDTH-1:0]   inp_A,
    input  logic [WIDTH-1:0]   inp_B,
    output logic               out_busy,
    output logic               out_done,
    output logic [2*WIDTH-1:0] out_P
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    count;
    logic             last_iter;
    logic             zero_op;

`ifdef SHIFT_ADD_MULT_ZERO_SKIP_EN
    assign zero_op = (inp_A == '0) || (inp_B == '0);
`else
    assign zero_op = 1'b0;
`endif

    // The add's carry-out lands in the MSB of hi after the shift, so no separate carry flop is kept.
    always_comb begin
        sum       = {1'b0, hi};
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, mcand};
        end
        hi_next   = sum[WIDTH:1];
        lo_next   = {sum[0], lo[WIDTH-1:1]};
        last_iter = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inp_start) begin
                    state_next = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign out_busy = (state == RUN);
    assign out_done = (state == DONE);

    always_ff @(posedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            out_P <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inp_start) begin
                        mcand <= inp_A;
                        lo    <= inp_B;
                        hi    <= '0;
                        count <= '0;
                        if (zero_op) begin
                            out_P <= '0;
                        end
                    end
                end
                RUN: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        out_P <= {hi_next, lo_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
